mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the accelerator memory interface (mem_req/mem_wr/mem_rd).
//  Synthesizable stand-in for the DPI memory model: accepts read/write burst requests
//  from an initiator (e.g. the Compute block), backed by an internal word RAM.
//  Provides a backdoor port for bench preload/inspection.
// PARAMETERS
//  MEM_LEN_BITS   8   width of burst length field (len = beats-1)
//  MEM_ADDR_BITS  64  byte address width
//  MEM_DATA_BITS  64  beat width; power of two >= 8
//  DEPTH          256 RAM words; power of two
// PORTS
//  clock          in  1              single clock
//  reset          in  1              synchronous, active-high
//  mem_req_valid  in  1              request strobe, one cycle per request
//  mem_req_opcode in  1              0 = read, 1 = write
//  mem_req_len    in  MEM_LEN_BITS   beats-1
//  mem_req_addr   in  MEM_ADDR_BITS  byte base address
//  mem_wr_valid   in  1              write beat strobe
//  mem_wr_bits    in  MEM_DATA_BITS  write beat data
//  mem_rd_valid   out 1              read beat valid
//  mem_rd_bits    out MEM_DATA_BITS  read beat data
//  mem_rd_ready   in  1              initiator accepts read beat
//  bd_we          in  1              backdoor write (honoured only in IDLE)
//  bd_addr        in  $clog2(DEPTH)  backdoor word index
//  bd_wdata       in  MEM_DATA_BITS  backdoor write data
//  bd_rdata       out MEM_DATA_BITS  backdoor read data, 1-cycle latency
//  busy           out 1              state != IDLE
//  err            out 1              sticky protocol-error flag, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; mem_rd_valid=0, mem_rd_bits=0, busy=0, err=0, bd_rdata=0.
//   RAM contents not reset. Reset mid-burst aborts the burst immediately.
//  Word index = (mem_req_addr >> log2(MEM_DATA_BITS/8)) mod DEPTH. Nonzero low byte-offset
//   bits set err; the offset is dropped. Index increments by 1 per beat and wraps DEPTH-1 -> 0.
//  Beat counter: MEM_LEN_BITS wide, loaded with len. Burst has len+1 beats (len=0 -> 1 beat,
//   len=255 -> 256 beats).
//  FSM states: IDLE, RD_FETCH, RD_DATA, WR_DATA.
//   IDLE: mem_req_valid latches idx/count. Opcode 0 -> RD_FETCH; opcode 1 -> WR_DATA.
//   RD_FETCH: 1-cycle RAM read. Then RD_DATA with mem_rd_valid=1.
//    The first beat is therefore valid 2 cycles after the request cycle.
//   RD_DATA: mem_rd_bits held stable while valid && !ready.
//    On valid && ready: last beat -> IDLE and valid drops the next cycle;
//    otherwise idx++, count--, RD_FETCH. Sustained rate is 1 beat per 2 cycles.
//   WR_DATA: each mem_wr_valid cycle writes mem_wr_bits to RAM[idx], then idx++, count--.
//    After the last beat -> IDLE. Idle cycles without wr_valid are allowed (no timeout).
//  Protocol errors set err and have no other effect:
//   - mem_req_valid while not IDLE, including the cycle of the final beat; the request is dropped.
//   - mem_wr_valid outside WR_DATA.
//   - mem_req_valid && mem_wr_valid in IDLE for a write: the beat is not taken as data.
//  Backdoor: bd_we in IDLE writes RAM[bd_addr]; bd_we outside IDLE is ignored and sets err.
//   bd_rdata = RAM[bd_addr] registered, valid every cycle the RAM port is free.
//   Otherwise bd_rdata holds its last value.
//  The RAM port is single; the FSM has priority over the backdoor.
// STRUCTURE
//  Package mem_responder_pkg: MEM_OP_RD=1'b0, MEM_OP_WR=1'b1, state_t enum.
//  Sub-module mem_responder_ram: single-port sync RAM, DEPTH x MEM_DATA_BITS, registered read.
//  Top: FSM, idx/count registers, port mux, err logic.
// TESTING
//  1 Backdoor preload RAM[4..7]=0x10..0x13; read req addr=0x20 len=3, ready=1
//    -> rd_bits 0x10,0x11,0x12,0x13 with first valid 2 cycles after req; busy drops after the last beat.
//  2 Same read with ready low for 3 cycles on beat 1 -> 0x11 held stable; no beat lost or duplicated.
//  3 Write req addr=0x7F8 (idx 255) len=1, beats 0xA,0xB
//    -> backdoor RAM[255]=0xA, RAM[0]=0xB (wrap); err=0.
//  4 Write req len=2 with gaps between wr_valid beats -> all 3 beats stored in order; IDLE after the third.
//  5 Errors: req_valid during RD_DATA; wr_valid in IDLE; addr=0x21
//    -> err=1 sticky; burst in progress unaffected.
//  6 reset asserted mid-read (beat 2 of 4) -> next cycle rd_valid=0, busy=0, err=0;
//    RAM retains its contents; a new read returns correct data.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - opcodes and FSM state type shared by the memory responder
package mem_responder_pkg;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_FETCH = 2'd1,
        ST_RD_DATA  = 2'd2,
        ST_WR_DATA  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// rtl/mem_responder_ram.sv - single-port synchronous word RAM with registered read
module mem_responder_ram #(
    parameter int  DATA_BITS = 64,
    parameter int  DEPTH     = 256,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     addr_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    output logic [DATA_BITS-1:0] rdata_o
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rdata_q;

    // Read-first: a write cycle returns the word's previous contents.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - burst read/write memory responder with backdoor port and sticky error flag
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int  MEM_LEN_BITS  = 8,
    parameter int  MEM_ADDR_BITS = 64,
    parameter int  MEM_DATA_BITS = 64,
    parameter int  DEPTH         = 256,
    localparam int IDX_W         = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    output logic                     mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    input  logic                     mem_rd_ready,
    input  logic                     bd_we,
    input  logic [IDX_W-1:0]         bd_addr,
    input  logic [MEM_DATA_BITS-1:0] bd_wdata,
    output logic [MEM_DATA_BITS-1:0] bd_rdata,
    output logic                     busy,
    output logic                     err
);

    localparam int OFF_W = $clog2(MEM_DATA_BITS / 8);
    localparam logic [MEM_ADDR_BITS-1:0] OFF_MASK = MEM_ADDR_BITS'((64'd1 << OFF_W) - 64'd1);

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [MEM_LEN_BITS-1:0]   cnt_q;
    logic                      rd_valid_q;
    logic                      err_q;
    logic                      bd_fresh_q;
    logic [MEM_DATA_BITS-1:0]  bd_hold_q;

    logic                      ram_we_d;
    logic [IDX_W-1:0]          ram_addr_d;
    logic [MEM_DATA_BITS-1:0]  ram_wdata_d;
    logic [MEM_DATA_BITS-1:0]  ram_rdata;
    logic                      port_free_d;
    logic                      err_set_d;

    // Reads keep the port on idx_q through RD_DATA so the registered RAM output stays stable under stall.
    always_comb begin
        ram_we_d    = 1'b0;
        ram_addr_d  = bd_addr;
        ram_wdata_d = bd_wdata;
        port_free_d = 1'b1;
        case (state_q)
            ST_IDLE: ram_we_d = bd_we;
            ST_RD_FETCH, ST_RD_DATA: begin
                ram_addr_d  = idx_q;
                port_free_d = 1'b0;
            end
            ST_WR_DATA: begin
                if (mem_wr_valid) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = idx_q;
                    ram_wdata_d = mem_wr_bits;
                    port_free_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        err_set_d = 1'b0;
        if (mem_req_valid && (state_q != ST_IDLE)) err_set_d = 1'b1;
        if (mem_wr_valid && (state_q != ST_WR_DATA)) err_set_d = 1'b1;
        if (bd_we && (state_q != ST_IDLE)) err_set_d = 1'b1;
        if (mem_req_valid && (state_q == ST_IDLE) && (|(mem_req_addr & OFF_MASK))) err_set_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (err_set_d) err_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_valid) begin
                        idx_q   <= mem_req_addr[OFF_W +: IDX_W];
                        cnt_q   <= mem_req_len;
                        state_q <= (mem_req_opcode == MEM_OP_WR) ? ST_WR_DATA : ST_RD_FETCH;
                    end
                end
                ST_RD_FETCH: begin
                    rd_valid_q <= 1'b1;
                    state_q    <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (mem_rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (cnt_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            cnt_q   <= cnt_q - MEM_LEN_BITS'(1);
                            state_q <= ST_RD_FETCH;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (mem_wr_valid) begin
                        idx_q <= idx_q + IDX_W'(1);
                        cnt_q <= cnt_q - MEM_LEN_BITS'(1);
                        if (cnt_q == '0) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Backdoor data is live only when the previous cycle's RAM access was the backdoor's.
    always_ff @(posedge clock) begin
        if (reset) begin
            bd_fresh_q <= 1'b0;
            bd_hold_q  <= '0;
        end else begin
            bd_fresh_q <= port_free_d;
            bd_hold_q  <= bd_rdata;
        end
    end

    mem_responder_ram #(
        .DATA_BITS (MEM_DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clock   (clock),
        .we_i    (ram_we_d),
        .addr_i  (ram_addr_d),
        .wdata_i (ram_wdata_d),
        .rdata_o (ram_rdata)
    );

    assign bd_rdata     = bd_fresh_q ? ram_rdata : bd_hold_q;
    assign mem_rd_valid = rd_valid_q;
    assign mem_rd_bits  = rd_valid_q ? ram_rdata : '0;
    assign busy         = (state_q != ST_IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder burst, backdoor and error behaviour
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req_valid = 1'b0;
    logic        mem_req_opcode = 1'b0;
    logic [7:0]  mem_req_len = '0;
    logic [63:0] mem_req_addr = '0;
    logic        mem_wr_valid = 1'b0;
    logic [63:0] mem_wr_bits = '0;
    logic        mem_rd_valid;
    logic [63:0] mem_rd_bits;
    logic        mem_rd_ready = 1'b1;
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [63:0] bd_wdata = '0;
    logic [63:0] bd_rdata;
    logic        busy;
    logic        err;

    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] model [256];
    logic [63:0] rd_q [$];
    logic [71:0] wr_q [$];

    mem_responder dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_bits    (mem_rd_bits),
        .mem_rd_ready   (mem_rd_ready),
        .bd_we          (bd_we),
        .bd_addr        (bd_addr),
        .bd_wdata       (bd_wdata),
        .bd_rdata       (bd_rdata),
        .busy           (busy),
        .err            (err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [63:0] d);
        bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        tick();
        bd_we = 1'b0;
        model[a] = d;
    endtask

    task automatic bd_read(input logic [7:0] a, output logic [63:0] d);
        bd_addr = a;
        tick();
        d = bd_rdata;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // stall/inject/abort beat arguments of -1 disable that feature
    task automatic do_read(input logic [63:0] addr, input int len, input int stall_beat,
                           input int stall_cyc, input int inject_beat, input int abort_beat);
        int          beat;
        int          stalled;
        int          budget;
        logic [7:0]  idx;
        logic [63:0] exp;
        idx = addr[10:3];
        for (int i = 0; i <= len; i++) begin
            rd_q.push_back(model[idx]);
            idx = idx + 8'd1;
        end
        mem_req_valid = 1'b1; mem_req_opcode = 1'b0; mem_req_len = 8'(len); mem_req_addr = addr;
        tick();
        mem_req_valid = 1'b0;
        n_total++;
        if (mem_rd_valid !== 1'b0) $display("FAIL rd_latency_fetch: rd_valid=%0b required 0", mem_rd_valid);
        else n_pass++;
        tick();
        n_total++;
        if (mem_rd_valid !== 1'b1) $display("FAIL rd_latency_first: rd_valid=%0b required 1", mem_rd_valid);
        else n_pass++;
        beat = 0; stalled = 0; budget = 0;
        while (rd_q.size() > 0 && budget < 3000) begin
            if (mem_rd_valid === 1'b1) begin
                if (beat == abort_beat) begin
                    reset = 1'b1;
                    tick();
                    rd_q.delete();
                    n_total += 3;
                    if (mem_rd_valid !== 1'b0) $display("FAIL abort_rd_valid: got %0b required 0", mem_rd_valid);
                    else n_pass++;
                    if (busy !== 1'b0) $display("FAIL abort_busy: got %0b required 0", busy);
                    else n_pass++;
                    if (err !== 1'b0) $display("FAIL abort_err: got %0b required 0", err);
                    else n_pass++;
                    reset = 1'b0;
                    return;
                end
                if (beat == inject_beat) begin
                    mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_addr = 64'h0;
                end
                n_total++;
                if (beat == stall_beat && stalled < stall_cyc) begin
                    mem_rd_ready = 1'b0;
                    stalled++;
                    if (mem_rd_bits !== rd_q[0]) $display("FAIL rd_hold beat %0d: got %0h required %0h", beat, mem_rd_bits, rd_q[0]);
                    else n_pass++;
                end else begin
                    mem_rd_ready = 1'b1;
                    exp = rd_q.pop_front();
                    if (mem_rd_bits !== exp) $display("FAIL rd_beat %0d: got %0h required %0h", beat, mem_rd_bits, exp);
                    else n_pass++;
                    beat++;
                end
            end else begin
                mem_rd_ready = 1'b1;
            end
            tick();
            mem_req_valid = 1'b0;
            budget++;
        end
        n_total += 3;
        if (rd_q.size() != 0) $display("FAIL rd_timeout: %0d beats outstanding required 0", rd_q.size());
        else n_pass++;
        rd_q.delete();
        if (mem_rd_valid !== 1'b0) $display("FAIL rd_valid_drop: got %0b required 0", mem_rd_valid);
        else n_pass++;
        if (busy !== 1'b0) $display("FAIL rd_busy_drop: got %0b required 0", busy);
        else n_pass++;
    endtask

    task automatic do_write(input logic [63:0] addr, input int len, input int gap, input logic [63:0] base);
        logic [7:0]  idx;
        logic [71:0] ent;
        logic [63:0] got;
        idx = addr[10:3];
        mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_len = 8'(len); mem_req_addr = addr;
        tick();
        mem_req_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            repeat (gap) tick();
            if (gap > 0) begin
                n_total++;
                if (busy !== 1'b1) $display("FAIL wr_gap_busy beat %0d: got %0b required 1", i, busy);
                else n_pass++;
            end
            mem_wr_valid = 1'b1; mem_wr_bits = base + 64'(i);
            model[idx] = mem_wr_bits;
            wr_q.push_back({idx, mem_wr_bits});
            idx = idx + 8'd1;
            tick();
            mem_wr_valid = 1'b0;
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL wr_busy_drop: got %0b required 0", busy);
        else n_pass++;
        while (wr_q.size() > 0) begin
            ent = wr_q.pop_front();
            bd_read(ent[71:64], got);
            n_total++;
            if (got !== ent[63:0]) $display("FAIL wr_store idx %0d: got %0h required %0h", ent[71:64], got, ent[63:0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_total += 5;
        if (mem_rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %0b required 0", mem_rd_valid); else n_pass++;
        if (mem_rd_bits !== 64'h0) $display("FAIL reset_rd_bits: got %0h required 0", mem_rd_bits); else n_pass++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", busy); else n_pass++;
        if (err !== 1'b0) $display("FAIL reset_err: got %0b required 0", err); else n_pass++;
        if (bd_rdata !== 64'h0) $display("FAIL reset_bd_rdata: got %0h required 0", bd_rdata); else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) bd_write(8'(i), {$urandom(), $urandom()});
        for (int i = 4; i < 8; i++) bd_write(8'(i), 64'h10 + 64'(i - 4));
    endtask

    task automatic test_read_burst();
        do_read(64'h20, 3, -1, 0, -1, -1);
        do_read(64'h7F8, 1, -1, 0, -1, -1);
    endtask

    task automatic test_read_backpressure();
        do_read(64'h20, 3, 1, 3, -1, -1);
    endtask

    task automatic test_write_wrap();
        do_write(64'h7F8, 1, 0, 64'hA);
        n_total++;
        if (err !== 1'b0) $display("FAIL wrap_err: got %0b required 0", err); else n_pass++;
    endtask

    task automatic test_write_gaps();
        do_write(64'h100, 2, 3, 64'hC0DE_0000);
    endtask

    task automatic test_errors();
        logic [63:0] got;
        do_read(64'h20, 3, -1, 0, 0, -1);
        n_total++;
        if (err !== 1'b1) $display("FAIL err_req_busy: got %0b required 1", err); else n_pass++;
        do_write(64'h300, 0, 0, 64'h5A5A);
        n_total++;
        if (err !== 1'b1) $display("FAIL err_sticky: got %0b required 1", err); else n_pass++;

        pulse_reset();
        mem_wr_valid = 1'b1; mem_wr_bits = 64'hF00D;
        tick();
        mem_wr_valid = 1'b0;
        n_total++;
        if (err !== 1'b1) $display("FAIL err_wr_idle: got %0b required 1", err); else n_pass++;

        pulse_reset();
        mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_len = 8'd0; mem_req_addr = 64'h48;
        mem_wr_valid = 1'b1; mem_wr_bits = 64'hDEAD;
        tick();
        mem_req_valid = 1'b0; mem_wr_bits = 64'h55;
        tick();
        mem_wr_valid = 1'b0;
        model[9] = 64'h55;
        bd_read(8'd9, got);
        n_total += 2;
        if (err !== 1'b1) $display("FAIL err_req_wr_same: got %0b required 1", err); else n_pass++;
        if (got !== 64'h55) $display("FAIL req_wr_same_data: got %0h required 55", got); else n_pass++;

        pulse_reset();
        do_read(64'h21, 0, -1, 0, -1, -1);
        n_total++;
        if (err !== 1'b1) $display("FAIL err_misaligned: got %0b required 1", err); else n_pass++;

        pulse_reset();
        mem_req_valid = 1'b1; mem_req_opcode = 1'b1; mem_req_len = 8'd0; mem_req_addr = 64'hF0;
        tick();
        mem_req_valid = 1'b0; bd_we = 1'b1; bd_addr = 8'd31; bd_wdata = 64'hBAD;
        tick();
        bd_we = 1'b0; mem_wr_valid = 1'b1; mem_wr_bits = 64'h77;
        tick();
        mem_wr_valid = 1'b0;
        model[30] = 64'h77;
        n_total += 3;
        if (err !== 1'b1) $display("FAIL err_bd_busy: got %0b required 1", err); else n_pass++;
        bd_read(8'd31, got);
        if (got !== model[31]) $display("FAIL bd_busy_ignored: got %0h required %0h", got, model[31]); else n_pass++;
        bd_read(8'd30, got);
        if (got !== 64'h77) $display("FAIL bd_busy_write: got %0h required 77", got); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] got;
        pulse_reset();
        do_read(64'h20, 3, -1, 0, -1, 2);
        for (int i = 4; i < 8; i++) begin
            bd_read(8'(i), got);
            n_total++;
            if (got !== model[i]) $display("FAIL retain idx %0d: got %0h required %0h", i, got, model[i]);
            else n_pass++;
        end
        do_read(64'h20, 3, -1, 0, -1, -1);
        n_total++;
        if (err !== 1'b0) $display("FAIL post_reset_err: got %0b required 0", err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_read_backpressure();
        test_write_wrap();
        test_write_gaps();
        test_errors();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
